// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;
    localparam int XS3_BIAS   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
import bcd_pkg::*;

module bcd_digit_adj (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // A digit of 5..9 becomes 8..12, so the 4-bit sum never wraps.
    assign o_digit = (i_digit >= DIGIT_W'(ADJ_THRESH)) ? (i_digit + DIGIT_W'(ADJ_ADD)) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional feature macro EXCESS3_OUT_EN adds a registered excess-3 copy of the result (xs3_out).
import bcd_pkg::*;

module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    busy
`ifdef EXCESS3_OUT_EN
    ,
    output logic [4*DIGITS-1:0]     xs3_out
`endif
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if ((BIN_W >= 31) || ((2 ** BIN_W) > (10 ** DIGITS))) begin : g_range_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_bcd_out;
    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_next;
    logic [BIN_W-1:0]   w_bin_next;
    logic               w_last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The bit leaving the accumulator is always 0 in range; recycling it into the
    // spent end of the binary register keeps every adjusted bit consumed.
    assign w_acc_next   = {w_adj[ACC_W-2:0], r_bin[BIN_W-1]};
    assign w_bin_next   = {r_bin[BIN_W-2:0], w_adj[ACC_W-1]};
    assign w_last_shift = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)     w_next = SHIFT;
            SHIFT:   if (w_last_shift) w_next = DONE;
            DONE:    if (out_ready)    w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bcd_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin <= bin_in;
                        r_acc <= '0;
                        r_cnt <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last_shift) begin
                        r_bcd_out <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXCESS3_OUT_EN
    logic [ACC_W-1:0] w_xs3_next;
    logic [ACC_W-1:0] r_xs3_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_xs3
        assign w_xs3_next[g*DIGIT_W +: DIGIT_W] = w_acc_next[g*DIGIT_W +: DIGIT_W] + DIGIT_W'(XS3_BIAS);
    end

    // Loaded on the same edge as bcd_out so both share one handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xs3_out <= '0;
        end else if ((r_state == SHIFT) && w_last_shift) begin
            r_xs3_out <= w_xs3_next;
        end
    end

    assign xs3_out = r_xs3_out;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT) || (r_state == DONE);
    assign bcd_out   = r_bcd_out;

endmodule
